// File: rtl/fpga_snark_prover_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_snark_prover_pkg
// Brief    : Shared constants, types and helpers for the MSM front end.
//            FPGA_SNARK_PROVER_SIGNED_DIGIT_EN selects signed-digit recoding.
// Revision : 1.0 - initial release
// ============================================================================
package fpga_snark_prover_pkg;

    localparam int DEF_DAT_BITS = 256;
    localparam int DEF_WIN_BITS = 4;
    localparam int DEF_IDX_BITS = 16;

`ifdef FPGA_SNARK_PROVER_SIGNED_DIGIT_EN
    localparam bit SIGNED_DIGIT_EN = 1'b1;
`else
    localparam bit SIGNED_DIGIT_EN = 1'b0;
`endif

    // Signed recoding needs one extra window to absorb the final carry.
    function automatic int num_win(input int dat_bits, input int win_bits, input bit signed_en);
        if (signed_en) begin
            return (dat_bits / win_bits) + 1;
        end
        return (dat_bits + win_bits - 1) / win_bits;
    endfunction

    localparam int DEF_NUM_WIN = num_win(DEF_DAT_BITS, DEF_WIN_BITS, SIGNED_DIGIT_EN);
    localparam int DEF_WIN_IDX_BITS = (DEF_NUM_WIN > 1) ? $clog2(DEF_NUM_WIN) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SLICE = 1'b1
    } slice_state_t;

    // Bucket entry layout at the default widths, for downstream consumers.
    typedef struct packed {
        logic [DEF_WIN_IDX_BITS-1:0] window;
        logic [DEF_WIN_BITS-1:0]     bucket;
        logic                        sign;
        logic [DEF_IDX_BITS-1:0]     point_idx;
        logic                        last;
    } bucket_entry_t;

endpackage
`default_nettype wire

// File: rtl/msm_digit_recode.sv
`default_nettype none
// ============================================================================
// Module   : msm_digit_recode
// Brief    : Turns one raw scalar window plus incoming carry into a bucket
//            digit. FPGA_SNARK_PROVER_SIGNED_DIGIT_EN enables signed digits.
// Revision : 1.0 - initial release
// ============================================================================
module msm_digit_recode #(
    parameter int WIN_BITS = 4
) (
    input  logic [WIN_BITS-1:0] i_raw,
    input  logic                i_carry,
    output logic [WIN_BITS-1:0] o_bucket,
    output logic                o_sign,
    output logic                o_carry
);

`ifdef FPGA_SNARK_PROVER_SIGNED_DIGIT_EN
    localparam logic [WIN_BITS:0] C_HALF = (WIN_BITS+1)'(1) << (WIN_BITS-1);

    logic [WIN_BITS:0] w_digit;

    assign w_digit = {1'b0, i_raw} + {{WIN_BITS{1'b0}}, i_carry};

    // Digits above half the window become negative; 2^W - d is taken modulo 2^W,
    // so d == 2^W gives a negative zero that still pushes a carry upward.
    always_comb begin
        o_bucket = w_digit[WIN_BITS-1:0];
        o_sign   = 1'b0;
        o_carry  = 1'b0;
        if (w_digit > C_HALF) begin
            o_bucket = '0 - w_digit[WIN_BITS-1:0];
            o_sign   = 1'b1;
            o_carry  = 1'b1;
        end
    end
`else
    logic w_unused_carry;

    assign w_unused_carry = i_carry;

    // Unsigned windows pass straight through as bucket indices.
    always_comb begin
        o_bucket = i_raw;
        o_sign   = 1'b0;
        o_carry  = 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/msm_scalar_slicer.sv
`default_nettype none
// ============================================================================
// Module   : msm_scalar_slicer
// Brief    : Slices (scalar, point index) pairs into per-window bucket entries,
//            least significant window first, one entry per cycle.
//            FPGA_SNARK_PROVER_SIGNED_DIGIT_EN enables signed-digit recoding.
// Revision : 1.0 - initial release
// ============================================================================
module msm_scalar_slicer
    import fpga_snark_prover_pkg::*;
#(
    parameter int DAT_BITS = DEF_DAT_BITS,
    parameter int WIN_BITS = DEF_WIN_BITS,
    parameter int IDX_BITS = DEF_IDX_BITS,
    localparam int NUM_WIN   = num_win(DAT_BITS, WIN_BITS, SIGNED_DIGIT_EN),
    localparam int WIN_IDX_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DAT_BITS-1:0]  i_scalar,
    input  logic [IDX_BITS-1:0]  i_point_idx,
    input  logic                 i_scalar_val,
    output logic                 o_scalar_rdy,
    output logic                 o_val,
    input  logic                 i_rdy,
    output logic [WIN_IDX_W-1:0] o_window,
    output logic [WIN_BITS-1:0]  o_bucket,
    output logic                 o_sign,
    output logic [IDX_BITS-1:0]  o_point_idx,
    output logic                 o_last
);

    // Scalar is held zero-padded to a whole number of windows.
    localparam int PAD_BITS = NUM_WIN * WIN_BITS;

    slice_state_t           r_state;
    logic [PAD_BITS-1:0]    r_scalar;
    logic                   r_carry;

    logic [PAD_BITS-1:0]    w_scalar_ext;
    logic [PAD_BITS-1:0]    w_raw_src;
    logic [WIN_BITS-1:0]    w_bucket;
    logic                   w_sign;
    logic                   w_carry;
    logic                   w_accept;
    logic                   w_advance;
    logic [WIN_IDX_W-1:0]   w_next_window;
    logic                   w_next_last;

    // Ready again in the very cycle the last window leaves, so scalars chain
    // without a bubble; this is combinational from i_rdy.
    assign o_scalar_rdy  = (r_state == ST_IDLE) | (o_val & o_last & i_rdy);
    assign w_accept      = i_scalar_val & o_scalar_rdy;
    assign w_advance     = ~o_val | i_rdy;

    // On accept the first window is cut from the incoming scalar directly so
    // that it is registered on the same edge.
    assign w_scalar_ext  = PAD_BITS'(i_scalar);
    assign w_raw_src     = w_accept ? w_scalar_ext : r_scalar;
    assign w_next_window = w_accept ? '0 : (o_window + WIN_IDX_W'(1));
    assign w_next_last   = (w_next_window == WIN_IDX_W'(NUM_WIN - 1));

    msm_digit_recode #(
        .WIN_BITS (WIN_BITS)
    ) u_recode (
        .i_raw    (w_raw_src[WIN_BITS-1:0]),
        .i_carry  (w_accept ? 1'b0 : r_carry),
        .o_bucket (w_bucket),
        .o_sign   (w_sign),
        .o_carry  (w_carry)
    );

    // Slicing FSM and output register; outputs only move when the slot is free
    // or being consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_scalar    <= '0;
            r_carry     <= 1'b0;
            o_val       <= 1'b0;
            o_window    <= '0;
            o_bucket    <= '0;
            o_sign      <= 1'b0;
            o_point_idx <= '0;
            o_last      <= 1'b0;
        end else if (w_advance) begin
            if (w_accept || (r_state == ST_SLICE && !o_last)) begin
                r_state  <= ST_SLICE;
                r_scalar <= w_raw_src >> WIN_BITS;
                r_carry  <= w_carry;
                o_val    <= 1'b1;
                o_window <= w_next_window;
                o_bucket <= w_bucket;
                o_sign   <= w_sign;
                o_last   <= w_next_last;
                if (w_accept) begin
                    o_point_idx <= i_point_idx;
                end
            end else begin
                r_state <= ST_IDLE;
                o_val   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msm_scalar_slicer.sv
`default_nettype none
// ============================================================================
// Module   : tb_msm_scalar_slicer
// Brief    : Directed bench for msm_scalar_slicer at DAT_BITS=8, WIN_BITS=4.
//            Expectations follow FPGA_SNARK_PROVER_SIGNED_DIGIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msm_scalar_slicer;

`ifdef FPGA_SNARK_PROVER_SIGNED_DIGIT_EN
    localparam int NW  = 3;
    localparam int WIW = 2;
`else
    localparam int NW  = 2;
    localparam int WIW = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     i_scalar;
    logic [7:0]     i_point_idx;
    logic           i_scalar_val;
    logic           o_scalar_rdy;
    logic           o_val;
    logic           i_rdy;
    logic [WIW-1:0] o_window;
    logic [3:0]     o_bucket;
    logic           o_sign;
    logic [7:0]     o_point_idx;
    logic           o_last;

    always #5 clk = ~clk;

    msm_scalar_slicer #(
        .DAT_BITS (8),
        .WIN_BITS (4),
        .IDX_BITS (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_scalar     (i_scalar),
        .i_point_idx  (i_point_idx),
        .i_scalar_val (i_scalar_val),
        .o_scalar_rdy (o_scalar_rdy),
        .o_val        (o_val),
        .i_rdy        (i_rdy),
        .o_window     (o_window),
        .o_bucket     (o_bucket),
        .o_sign       (o_sign),
        .o_point_idx  (o_point_idx),
        .o_last       (o_last)
    );

    typedef struct {
        logic [7:0]      scalar;
        logic [7:0]      idx;
        logic [2:0][3:0] bkt;   // {w2, w1, w0}
        logic [2:0]      sgn;   // {w2, w1, w0}
    } vec_t;

    vec_t vt[6];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [16:0] act_entry();
        logic [1:0] wz;
        wz = '0;
        wz[WIW-1:0] = o_window;
        return {o_val, wz, o_bucket, o_sign, o_point_idx, o_last};
    endfunction

    function automatic logic [16:0] exp_entry(input int v, input int w);
        return {1'b1, 2'(w), vt[v].bkt[w], vt[v].sgn[w], vt[v].idx, (w == NW - 1)};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        i_scalar_val = 1'b1;
        i_scalar     = vt[v].scalar;
        i_point_idx  = vt[v].idx;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FPGA_SNARK_PROVER_SIGNED_DIGIT_EN
        vt[0] = '{8'hF7, 8'h05, {4'd1, 4'd1,  4'd7},  3'b010};
        vt[1] = '{8'h00, 8'h00, {4'd0, 4'd0,  4'd0},  3'b000};
        vt[2] = '{8'hFF, 8'hAB, {4'd1, 4'd0,  4'd1},  3'b011};
        vt[3] = '{8'h88, 8'h03, {4'd0, 4'd8,  4'd8},  3'b000};
        vt[4] = '{8'h1E, 8'h07, {4'd0, 4'd2,  4'd2},  3'b001};
        vt[5] = '{8'h9A, 8'h09, {4'd1, 4'd6,  4'd6},  3'b011};
`else
        vt[0] = '{8'hF7, 8'h05, {4'd0, 4'd15, 4'd7},  3'b000};
        vt[1] = '{8'h00, 8'h00, {4'd0, 4'd0,  4'd0},  3'b000};
        vt[2] = '{8'hFF, 8'hAB, {4'd0, 4'd15, 4'd15}, 3'b000};
        vt[3] = '{8'h88, 8'h03, {4'd0, 4'd8,  4'd8},  3'b000};
        vt[4] = '{8'h1E, 8'h07, {4'd0, 4'd1,  4'd14}, 3'b000};
        vt[5] = '{8'h9A, 8'h09, {4'd0, 4'd9,  4'd10}, 3'b000};
`endif
        rst          = 1'b1;
        i_scalar     = '0;
        i_point_idx  = '0;
        i_scalar_val = 1'b0;
        i_rdy        = 1'b1;
        #1;
        check("reset_outputs", act_entry(), 17'd0);
        check("reset_rdy", 17'(o_scalar_rdy), 17'd1);
        step();
        step();
        rst = 1'b0;
        step();

        // Table vectors, downstream always ready.
        for (int v = 0; v < 6; v++) begin
            send(v);
            check($sformatf("vec%0d_rdy", v), 17'(o_scalar_rdy), 17'd1);
            step();
            i_scalar_val = 1'b0;
            for (int w = 0; w < NW; w++) begin
                check($sformatf("vec%0d_w%0d", v, w), act_entry(), exp_entry(v, w));
                step();
            end
            check($sformatf("vec%0d_idle", v), 17'(o_val), 17'd0);
        end

        // Backpressure on window 1 for three cycles.
        send(5);
        step();
        i_scalar_val = 1'b0;
        check("bp_w0", act_entry(), exp_entry(5, 0));
        step();
        check("bp_w1", act_entry(), exp_entry(5, 1));
        i_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("bp_hold%0d", k), act_entry(), exp_entry(5, 1));
        end
        check("bp_rdy_low", 17'(o_scalar_rdy), 17'd0);
        i_rdy = 1'b1;
        step();
        for (int w = 2; w < NW; w++) begin
            check($sformatf("bp_w%0d", w), act_entry(), exp_entry(5, w));
            step();
        end
        check("bp_idle", 17'(o_val), 17'd0);

        // Back-to-back scalars with valid held high.
        send(0);
        step();
        i_scalar    = vt[4].scalar;
        i_point_idx = vt[4].idx;
        for (int w = 0; w < NW; w++) begin
            check($sformatf("b2b_a_w%0d", w), act_entry(), exp_entry(0, w));
            check($sformatf("b2b_rdy_w%0d", w), 17'(o_scalar_rdy), 17'(w == NW - 1));
            step();
        end
        i_scalar_val = 1'b0;
        for (int w = 0; w < NW; w++) begin
            check($sformatf("b2b_b_w%0d", w), act_entry(), exp_entry(4, w));
            step();
        end
        check("b2b_idle", 17'(o_val), 17'd0);

        // Asynchronous reset in the middle of a scalar.
        send(2);
        step();
        i_scalar_val = 1'b0;
        check("rst_w0", act_entry(), exp_entry(2, 0));
        step();
        check("rst_w1", act_entry(), exp_entry(2, 1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", act_entry(), 17'd0);
        #2;
        rst = 1'b0;
        check("rst_rdy", 17'(o_scalar_rdy), 17'd1);
        step();
        send(0);
        step();
        i_scalar_val = 1'b0;
        for (int w = 0; w < NW; w++) begin
            check($sformatf("rst_new_w%0d", w), act_entry(), exp_entry(0, w));
            step();
        end
        check("rst_new_idle", 17'(o_val), 17'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msm_scalar_slicer.md
Name: msm_scalar_slicer

Overview:
- Front end of the Pippenger multi-scalar-multiplication engine.
- Accepts one (scalar, point index) pair at a time and slices the scalar into WIN_BITS windows, least significant first.
- Emits one bucket entry (window, bucket, sign, point index) per cycle towards the bucket accumulators.
- Generalises the fixed-width slicing used so far: scalar width, window width and index width are parametrised, and signed-digit recoding is optional.

Parameters:
- DAT_BITS, 256, scalar width in bits.
- WIN_BITS, 4, window width in bits (2..16).
- IDX_BITS, 16, point index width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_scalar  in  DAT_BITS  scalar value
- i_point_idx  in  IDX_BITS  index of the curve point paired with the scalar
- i_scalar_val  in  1  scalar valid
- o_scalar_rdy  out  1  block can accept a scalar
- o_val  out  1  bucket entry valid
- i_rdy  in  1  downstream ready
- o_window  out  $clog2(NUM_WIN)  window number, 0 = least significant
- o_bucket  out  WIN_BITS  bucket index (digit magnitude)
- o_sign  out  1  1 = subtract point (signed mode only, else 0)
- o_point_idx  out  IDX_BITS  copy of i_point_idx
- o_last  out  1  final window of the current scalar

Behaviour:
- Window count:
  - Unsigned: NUM_WIN = ceil(DAT_BITS/WIN_BITS).
  - Signed: NUM_WIN = floor(DAT_BITS/WIN_BITS)+1.
  - Raw windows above bit DAT_BITS-1 are zero-padded.
- Reset (async, i_rst=1):
  - FSM goes to IDLE.
  - o_val, o_window, o_bucket, o_sign, o_point_idx, o_last all drop to 0.
  - Any scalar in flight is discarded; no partial entries appear after reset.
- FSM states:
  - IDLE -> SLICE on i_scalar_val & o_scalar_rdy.
  - SLICE -> IDLE when the last window is accepted (o_val & i_rdy & o_last) and no new scalar is accepted in the same cycle.
  - SLICE -> SLICE when a new scalar is accepted in that same cycle.
- Scalar accept:
  - o_scalar_rdy = (state==IDLE) | (o_val & o_last & i_rdy). This is a combinational path from i_rdy.
  - On accept, scalar, point index and window counter 0 are latched, and carry is cleared.
- Latency and throughput:
  - Scalar accepted in cycle N gives its first entry registered with o_val=1 in cycle N+1.
  - Sustained throughput is one scalar per NUM_WIN cycles, with no bubble between scalars.
- Output register:
  - Advances when !o_val | i_rdy.
  - While o_val & !i_rdy, every output holds stable.
  - o_val falls after the last entry is accepted, unless a new scalar was accepted in that cycle.
- Unsigned digit: o_bucket = raw window; o_sign = 0.
- Signed digit (with macro):
  - d = raw + carry, computed in WIN_BITS+1 bits.
  - If d > 2^(WIN_BITS-1): o_bucket = 2^WIN_BITS - d, o_sign = 1, next carry = 1.
  - Otherwise: o_bucket = d, o_sign = 0, next carry = 0.
  - The top window never produces a carry, because its raw value is at most 2^(WIN_BITS-1)-1.
- Zero digits are emitted (bucket 0) and never skipped, so o_last is always on window NUM_WIN-1.
- i_scalar_val without o_scalar_rdy is ignored. i_scalar and i_point_idx are sampled only on accept.

Optional Feature:
- Macro: FPGA_SNARK_PROVER_SIGNED_DIGIT_EN.
- Defined: signed-digit recoding as above. Halves the bucket count downstream (buckets 1..2^(WIN_BITS-1)); o_sign is live.
- Undefined: plain unsigned windows; o_sign tied to 0; NUM_WIN uses the ceil formula.

Decomposition:
- fpga_snark_prover_pkg holds:
  - default DAT_BITS/WIN_BITS/IDX_BITS constants;
  - a function num_win(dat_bits, win_bits, signed_en);
  - a packed struct bucket_entry_t {window, bucket, sign, point_idx, last}.
- One natural combinational sub-module: msm_digit_recode (raw window + carry in; bucket, sign, carry out). The macro selects its signed path.

Test Plan:
- Unsigned, DAT_BITS=8, WIN_BITS=4: scalar 0xF7, idx 5, i_rdy=1 -> entries (w0,b7,s0,idx5,last0), then (w1,b15,s0,idx5,last1); first entry one cycle after accept.
- Signed, same widths, scalar 0xF7 -> (w0,b7,+), (w1,b1,−), (w2,b1,+,last); reconstructs 7−16+256=247. Scalar 0x88 -> (8,+), (8,+), (0,+,last).
- Backpressure: i_rdy low for 3 cycles mid-scalar -> outputs stable; no entry lost or duplicated.
- Back-to-back: two scalars with i_scalar_val held high and i_rdy=1 -> the second scalar's w0 follows the first's last entry with no gap; o_scalar_rdy pulses on the last-window cycle.
- Reset asserted mid-scalar (after w1) -> o_val drops to 0 immediately (asynchronously) and o_scalar_rdy=1 after release. A new scalar restarts at w0 with carry 0.
- Random regression, DAT_BITS=256, WIN_BITS=4/5/7, both macro settings -> the sum of sign*bucket*2^(w*WIN_BITS) equals the scalar for 10k scalars.
